// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and
// the owner codes used on the owner output and inside the round-robin picker.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_IO  = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins outright, a tie goes to
// whichever requester was not granted last.
module rr_pick2
    import data_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    // req[0] is the CPU, req[1] is the IO port; with no request the result is unused
    always_comb begin
        grant = OWN_CPU;
        if (req == 2'b11) begin
            grant = ~last;
        end else if (req[1]) begin
            grant = OWN_IO;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates a single-port synchronous-read data memory between the CPU memory
// stage and the keypad/display IO port; one access per two cycles.
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ready,
    output logic [DW-1:0] cpu_rdata,

    input  logic          io_req,
    input  logic          io_we,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_wdata,
    output logic          io_ready,
    output logic [DW-1:0] io_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy,
    output logic          owner
);

    arb_state_t    state, state_nxt;
    logic          owner_q, owner_nxt;
    logic          last_grant;
    logic          txn_we_q;
    logic [DW-1:0] cpu_rdata_q, io_rdata_q;

    logic [1:0]    pick_req;
    logic          pick_last;
    logic          pick;

    // In RESP only the requester that is not finishing may take the next slot
    assign pick_req  = (state == RESP) ?
                       ((owner_q == OWN_CPU) ? {io_req, 1'b0} : {1'b0, cpu_req}) :
                       {io_req, cpu_req};
    assign pick_last = (state == RESP) ? owner_q : last_grant;

    rr_pick2 u_pick (
        .req   (pick_req),
        .last  (pick_last),
        .grant (pick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner_q     <= OWN_CPU;
            last_grant  <= OWN_IO;
            txn_we_q    <= 1'b0;
            cpu_rdata_q <= '0;
            io_rdata_q  <= '0;
        end else begin
            state   <= state_nxt;
            owner_q <= owner_nxt;
            if (state == ISSUE) begin
                txn_we_q <= mem_we;
            end
            if (state == RESP) begin
                last_grant <= owner_q;
                if (!txn_we_q && owner_q == OWN_CPU) begin
                    cpu_rdata_q <= mem_rdata;
                end
                if (!txn_we_q && owner_q == OWN_IO) begin
                    io_rdata_q <= mem_rdata;
                end
            end
        end
    end

    // Read data is passed straight through in RESP so it coincides with ready
    always_comb begin
        state_nxt = state;
        owner_nxt = owner_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_ready = 1'b0;
        io_ready  = 1'b0;
        cpu_rdata = cpu_rdata_q;
        io_rdata  = io_rdata_q;
        busy      = 1'b0;
        owner     = OWN_CPU;

        case (state)
            IDLE: begin
                if (|pick_req) begin
                    state_nxt = ISSUE;
                    owner_nxt = pick;
                end
            end
            ISSUE: begin
                busy      = 1'b1;
                owner     = owner_q;
                mem_en    = 1'b1;
                mem_we    = (owner_q == OWN_IO) ? io_we    : cpu_we;
                mem_addr  = (owner_q == OWN_IO) ? io_addr  : cpu_addr;
                mem_wdata = (owner_q == OWN_IO) ? io_wdata : cpu_wdata;
                state_nxt = RESP;
            end
            RESP: begin
                busy  = 1'b1;
                owner = owner_q;
                if (owner_q == OWN_CPU) begin
                    cpu_ready = 1'b1;
                    if (!txn_we_q) begin
                        cpu_rdata = mem_rdata;
                    end
                end else begin
                    io_ready = 1'b1;
                    if (!txn_we_q) begin
                        io_rdata = mem_rdata;
                    end
                end
                if (|pick_req) begin
                    state_nxt = ISSUE;
                    owner_nxt = pick;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios followed by
// randomized traffic checked against a transaction-level reference model.
module tb_data_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req, cpu_we, io_req, io_we;
    logic [AW-1:0] cpu_addr, io_addr;
    logic [DW-1:0] cpu_wdata, io_wdata;
    logic          cpu_ready, io_ready;
    logic [DW-1:0] cpu_rdata, io_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy, owner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .io_req    (io_req),
        .io_we     (io_we),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_ready  (io_ready),
        .io_rdata  (io_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .owner     (owner)
    );

    // Synchronous-read single-port memory, 256 words
    logic [DW-1:0] mem [0:255] = '{default: '0};

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input bit port, input bit req, input bit we,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (port == 1'b0) begin
            cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end else begin
            io_req = req; io_we = we; io_addr = addr; io_wdata = wdata;
        end
    endtask

    // Reference model: phase 0 free, 1 memory access in flight, 2 response
    logic [DW-1:0] ref_mem [0:255];
    int            phase;
    bit            cur, last, c, r;
    bit            t_we;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata;
    logic [DW-1:0] exp_cpu_rd, exp_io_rd;
    bit            cpu_pend, io_pend;

    initial begin
        applyStimulus(0, 0, 0, '0, '0);
        applyStimulus(1, 0, 0, '0, '0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy",   busy, 0);
        checkOutput("rst_owner",  owner, 0);
        checkOutput("rst_mem_en", mem_en, 0);
        checkOutput("rst_ready",  {cpu_ready, io_ready}, 0);
        checkOutput("rst_rdata",  {cpu_rdata, io_rdata}, 0);
        rst = 1'b0;

        // CPU write then read-back of the same word
        applyStimulus(0, 1, 1, 12, 989);
        @(negedge clk);
        checkOutput("wr_mem_en", mem_en, 1);
        checkOutput("wr_mem_we", mem_we, 1);
        checkOutput("wr_addr",   mem_addr, 12);
        checkOutput("wr_wdata",  mem_wdata, 989);
        checkOutput("wr_early_ready", cpu_ready, 0);
        @(negedge clk);
        checkOutput("wr_ready",   cpu_ready, 1);
        checkOutput("wr_resp_en", mem_en, 0);
        applyStimulus(0, 0, 0, '0, '0);
        @(negedge clk);
        checkOutput("wr_idle_busy", busy, 0);
        applyStimulus(0, 1, 0, 12, 0);
        @(negedge clk);
        checkOutput("rd_mem_we", mem_we, 0);
        @(negedge clk);
        checkOutput("rd_ready", cpu_ready, 1);
        checkOutput("rd_rdata", cpu_rdata, 989);
        applyStimulus(0, 0, 0, '0, '0);
        @(negedge clk);
        checkOutput("rd_hold", cpu_rdata, 989);
        checkOutput("rd_ready_pulse", cpu_ready, 0);

        // Simultaneous requests straight after reset: CPU first, IO back-to-back
        rst = 1'b1;
        #1 checkOutput("rst2_rdata", cpu_rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 1, 1, 13, 4554);
        applyStimulus(1, 1, 0, 12, 0);
        @(negedge clk);
        checkOutput("tie_owner", owner, 0);
        checkOutput("tie_addr",  mem_addr, 13);
        checkOutput("tie_wdata", mem_wdata, 4554);
        @(negedge clk);
        checkOutput("tie_cpu_ready", {cpu_ready, io_ready}, 2'b10);
        applyStimulus(0, 0, 0, '0, '0);
        @(negedge clk);
        checkOutput("b2b_busy",  busy, 1);
        checkOutput("b2b_owner", owner, 1);
        checkOutput("b2b_addr",  mem_addr, 12);
        checkOutput("b2b_en",    mem_en, 1);
        @(negedge clk);
        checkOutput("b2b_io_ready", {cpu_ready, io_ready}, 2'b01);
        checkOutput("b2b_io_rdata", io_rdata, 989);
        applyStimulus(1, 0, 0, '0, '0);
        @(negedge clk);
        checkOutput("b2b_idle", busy, 0);

        // Both requesters held: grants alternate
        applyStimulus(0, 1, 0, 13, 0);
        applyStimulus(1, 1, 0, 12, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("alt_owner", owner, (i / 2) % 2);
            checkOutput("alt_cpu_ready", cpu_ready, (i % 4) == 1);
            checkOutput("alt_io_ready",  io_ready,  (i % 4) == 3);
            if (i == 1) checkOutput("alt_cpu_rdata", cpu_rdata, 4554);
        end
        applyStimulus(0, 0, 0, '0, '0);
        applyStimulus(1, 0, 0, '0, '0);
        @(negedge clk);
        checkOutput("alt_idle", busy, 0);

        // Reset during an IO write access
        applyStimulus(1, 1, 1, 20, 77);
        @(negedge clk);
        checkOutput("abort_we_before", mem_we, 1);
        checkOutput("abort_owner", owner, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_we",   mem_we, 0);
        checkOutput("abort_en",   mem_en, 0);
        checkOutput("abort_busy", busy, 0);
        @(negedge clk);
        checkOutput("abort_no_ready", io_ready, 0);
        checkOutput("abort_no_write", mem[20], 0);
        rst = 1'b0;
        applyStimulus(1, 0, 0, '0, '0);

        // Tie after reset goes to CPU; IO then drops its req during ISSUE
        applyStimulus(0, 1, 0, 13, 0);
        applyStimulus(1, 1, 0, 12, 0);
        @(negedge clk);
        checkOutput("post_rst_owner", owner, 0);
        @(negedge clk);
        checkOutput("post_rst_cpu_ready", cpu_ready, 1);
        applyStimulus(0, 0, 0, '0, '0);
        @(negedge clk);
        checkOutput("drop_owner", owner, 1);
        io_req = 1'b0;
        @(negedge clk);
        checkOutput("drop_ready", io_ready, 1);
        checkOutput("drop_rdata", io_rdata, 989);
        @(negedge clk);
        checkOutput("drop_idle", {busy, io_ready}, 0);

        // Randomized traffic against the reference model
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        phase = 0; cur = 0; last = 1;
        exp_cpu_rd = '0; exp_io_rd = '0;
        cpu_pend = 0; io_pend = 0;
        t_we = 0; t_addr = '0; t_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

        for (int cyc = 0; cyc < 400; cyc++) begin
            if (phase == 2 && !t_we) begin
                if (cur == 0) exp_cpu_rd = ref_mem[t_addr[7:0]];
                else          exp_io_rd  = ref_mem[t_addr[7:0]];
            end
            checkOutput("rnd_mem_en",    mem_en, phase == 1);
            checkOutput("rnd_mem_we",    mem_we, (phase == 1) && t_we);
            checkOutput("rnd_mem_addr",  mem_addr,  (phase == 1) ? t_addr  : '0);
            checkOutput("rnd_mem_wdata", mem_wdata, (phase == 1) ? t_wdata : '0);
            checkOutput("rnd_cpu_ready", cpu_ready, (phase == 2) && (cur == 0));
            checkOutput("rnd_io_ready",  io_ready,  (phase == 2) && (cur == 1));
            checkOutput("rnd_busy",      busy, phase != 0);
            checkOutput("rnd_owner",     owner, (phase != 0) ? cur : 1'b0);
            checkOutput("rnd_cpu_rdata", cpu_rdata, exp_cpu_rd);
            checkOutput("rnd_io_rdata",  io_rdata,  exp_io_rd);
            if (phase == 2 && t_we) ref_mem[t_addr[7:0]] = t_wdata;

            if (cpu_pend && phase == 2 && cur == 0) begin
                cpu_pend = 0; cpu_req = 0;
            end else if (cpu_pend && phase == 1 && cur == 0 && $urandom_range(7) == 0) begin
                cpu_req = 0;
            end
            if (!cpu_pend && $urandom_range(1) == 1) begin
                cpu_pend = 1;
                applyStimulus(0, 1, 1'($urandom_range(1)), {24'd0, 8'($urandom_range(255))}, $urandom);
            end
            if (io_pend && phase == 2 && cur == 1) begin
                io_pend = 0; io_req = 0;
            end else if (io_pend && phase == 1 && cur == 1 && $urandom_range(7) == 0) begin
                io_req = 0;
            end
            if (!io_pend && $urandom_range(1) == 1) begin
                io_pend = 1;
                applyStimulus(1, 1, 1'($urandom_range(1)), {24'd0, 8'($urandom_range(255))}, $urandom);
            end

            @(posedge clk);
            if (phase == 1) begin
                phase = 2;
            end else begin
                c = cpu_req;
                r = io_req;
                if (phase == 2) begin
                    last = cur;
                    if (cur == 0) c = 0;
                    else          r = 0;
                end
                if (c || r) begin
                    cur     = (c && r) ? ~last : r;
                    phase   = 1;
                    t_we    = cur ? io_we    : cpu_we;
                    t_addr  = cur ? io_addr  : cpu_addr;
                    t_wdata = cur ? io_wdata : cpu_wdata;
                end else begin
                    phase = 0;
                end
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have port clk  input  1  the single system clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports cpu_req / cpu_we  input  1 each  CPU memory-stage request and write enable.
REQ-006 SHALL have ports cpu_addr  input  AW and cpu_wdata  input  DW  CPU address (ALU result) and store data.
REQ-007 SHALL have ports cpu_ready  output  1 and cpu_rdata  output  DW  CPU completion pulse and load data.
REQ-008 SHALL have ports io_req, io_we  input  1 each; io_addr  input  AW; io_wdata  input  DW  keypad/display port request.
REQ-009 SHALL have ports io_ready  output  1 and io_rdata  output  DW  IO completion pulse and read data.
REQ-010 SHALL have ports mem_en, mem_we  output  1 each; mem_addr  output  AW; mem_wdata  output  DW  to the single-port data memory.
REQ-011 SHALL have port mem_rdata  input  DW  memory read data, valid the cycle after mem_en (synchronous read).
REQ-012 SHALL have ports busy  output  1 and owner  output  1 (0=CPU, 1=IO)  current grant.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-014 IDLE: no req -> IDLE; one req -> ISSUE for that requester; both -> ISSUE for the requester not granted last (round-robin).
REQ-015 ISSUE (1 cycle): mem_en=1, mem_we/addr/wdata from owner's inputs; always -> RESP.
REQ-016 RESP (1 cycle): owner's ready=1, owner's rdata=mem_rdata (write: rdata value don't-care, held at last value); last_grant <= owner.
REQ-017 From RESP: other requester's req=1 -> ISSUE for it; else -> IDLE (the finishing requester's req is ignored in RESP).
REQ-018 Latency: req seen in IDLE -> ready exactly 2 cycles later; sustained throughput one access per 2 cycles.
REQ-019 Requester SHALL hold req, we, addr, wdata stable until its ready; arbiter samples them combinationally during ISSUE only.
REQ-020 req dropped during ISSUE SHALL NOT abort: access completes, ready still pulses.
REQ-021 ready SHALL be a single-cycle pulse; never asserted to both requesters in one cycle.
REQ-022 mem_en, mem_we SHALL be 0 outside ISSUE; mem_addr/mem_wdata SHALL be 0 outside ISSUE.
REQ-023 busy=1 in ISSUE and RESP; owner valid when busy, 0 in IDLE.
REQ-024 rdata outputs SHALL be registered-hold: update only in the owner's RESP cycle.
REQ-025 Widths pass through unchanged; no address translation or alignment checking.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, last_grant=IO (so CPU wins the first tie), all outputs 0.
REQ-027 rst asserted during ISSUE SHALL deassert mem_we asynchronously; the aborted access gets no ready.
REQ-028 After rst release, first arbitration occurs on the first rising edge with rst=0.

Structure
REQ-029 Shared package data_mem_pkg SHALL hold state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2) and owner constants OWN_CPU=1'b0, OWN_IO=1'b1.
REQ-030 Round-robin selection SHALL be a sub-module rr_pick2 (inputs req[1:0], last; output grant); FSM and muxing stay in data_mem_arbiter.
REQ-031 Unused state encoding 2'd3 SHALL return to IDLE.

Verification
REQ-032 CPU write: cpu_req, cpu_we=1, addr=12, wdata=989 -> mem_en/we=1, addr 12 in cycle 1; cpu_ready in cycle 2.
REQ-033 CPU read after write: addr=12, we=0, memory model returns 989 -> cpu_rdata=989 with cpu_ready, 2 cycles after req.
REQ-034 Simultaneous reqs after reset: CPU addr 13 wdata 4554, IO addr 12 read -> CPU ISSUE/RESP, then IO ISSUE/RESP directly (no IDLE); io_rdata=989.
REQ-035 Both reqs held continuously 8 cycles -> grants alternate CPU, IO, CPU, IO; each ready once per 4 cycles.
REQ-036 rst pulsed during IO ISSUE write -> mem_we falls same cycle, no io_ready, busy=0, next tie goes to CPU.
REQ-037 io_req dropped mid-ISSUE -> io_ready still pulses in RESP; FSM then IDLE.
